// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the asynchronous-SRAM bridge.
// Optional byte enables are enabled by defining SRAM_BRIDGE_BYTE_EN_EN.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned val);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter for ACCESS wait states; tc_o is high when the count is zero.
module sram_wait_cnt
  import sram_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic tc_o
);

  localparam int unsigned CntW = clog2_min1(WAIT_STATES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(WAIT_STATES);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bridge.sv
// Valid/ready bridge to an asynchronous SRAM with wait states, page register and bus turnaround.
// Define SRAM_BRIDGE_BYTE_EN_EN to add req_be / sram_be_n byte-lane enables.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SRAM_ADDR_W = 19,
  parameter int unsigned WAIT_STATES = 1,
  localparam int unsigned PAGE_W     = SRAM_ADDR_W - ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  input  logic                   page_we,
  input  logic [PAGE_W-1:0]      page_wdata,
  output logic [PAGE_W-1:0]      page_q,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
`ifdef SRAM_BRIDGE_BYTE_EN_EN
  input  logic [DATA_W/8-1:0]    req_be,
  output logic [DATA_W/8-1:0]    sram_be_n,
`endif
  inout  wire  [DATA_W-1:0]      sram_dq,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  state_e                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   we_q, we_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [PAGE_W-1:0]      page_d;
  logic                   cnt_load, cnt_dec, cnt_tc;
  logic                   busy;
  logic                   dq_oe;

`ifdef SRAM_BRIDGE_BYTE_EN_EN
  logic [DATA_W/8-1:0]    be_q, be_d;
`endif

  sram_wait_cnt #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    page_d   = page_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef SRAM_BRIDGE_BYTE_EN_EN
    be_d     = be_q;
`endif

    if (page_we) begin
      page_d = page_wdata;
    end

    unique case (state_q)
      IDLE: begin
        // The accepted request uses the page value from before this edge.
        if (req_valid) begin
          state_d = SETUP;
          addr_d  = {page_q, req_addr};
          we_d    = req_we;
          wdata_d = req_wdata;
`ifdef SRAM_BRIDGE_BYTE_EN_EN
          be_d    = req_be;
`endif
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        cnt_load = 1'b1;
      end
      ACCESS: begin
        if (cnt_tc) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = sram_dq;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      page_q  <= '0;
`ifdef SRAM_BRIDGE_BYTE_EN_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      page_q  <= page_d;
`ifdef SRAM_BRIDGE_BYTE_EN_EN
      be_q    <= be_d;
`endif
    end
  end

  // Strobes decode straight from the state flops; DONE releases everything for turnaround.
  always_comb begin
    busy      = (state_q == SETUP) || (state_q == ACCESS);
    sram_ce_n = busy ? STROBE_ON : STROBE_OFF;
    sram_oe_n = (busy && !we_q) ? STROBE_ON : STROBE_OFF;
    sram_we_n = ((state_q == ACCESS) && we_q) ? STROBE_ON : STROBE_OFF;
    dq_oe     = busy && we_q;
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
`ifdef SRAM_BRIDGE_BYTE_EN_EN
    sram_be_n = '1;
    if (busy) begin
      sram_be_n = we_q ? ~be_q : '0;
    end
`endif
  end

  assign sram_dq   = dq_oe ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr = addr_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: WAIT_STATES=1 instance with an SRAM model, plus a
// WAIT_STATES=0 instance for back-to-back traffic. Build with SRAM_BRIDGE_BYTE_EN_EN for byte lanes.
module tb_sram_bridge;

  localparam int WS = 1;

  typedef struct {
    logic        is_read;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance, WAIT_STATES = 1
  logic        req_valid = 1'b0, req_we = 1'b0, page_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  page_wdata = '0;
  logic        req_ready, rsp_valid, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] rsp_rdata;
  logic [2:0]  page_q;
  logic [18:0] sram_addr;
  wire  [15:0] sram_dq;
`ifdef SRAM_BRIDGE_BYTE_EN_EN
  logic [1:0]  req_be = 2'b11;
  logic [1:0]  sram_be_n;
`endif

  sram_bridge #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .SRAM_ADDR_W (19),
    .WAIT_STATES (WS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .page_we    (page_we),
    .page_wdata (page_wdata),
    .page_q     (page_q),
    .sram_addr  (sram_addr),
`ifdef SRAM_BRIDGE_BYTE_EN_EN
    .req_be     (req_be),
    .sram_be_n  (sram_be_n),
`endif
    .sram_dq    (sram_dq),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  // Asynchronous SRAM model, indexed by the low address bits
  logic [15:0] mem [0:1023] = '{default: 16'hFFFF};
  logic        mem_rd_en;
  assign mem_rd_en = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq   = mem_rd_en ? mem[sram_addr[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
`ifdef SRAM_BRIDGE_BYTE_EN_EN
      for (int b = 0; b < 2; b++) begin
        if (!sram_be_n[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_dq[8*b +: 8];
      end
`else
      mem[sram_addr[9:0]] <= sram_dq;
`endif
    end
  end

  // Second instance, WAIT_STATES = 0, read data is addr ^ A5A5
  logic        b_valid = 1'b0, b_we = 1'b0;
  logic [15:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_rsp_valid, b_ce_n, b_oe_n, b_we_n;
  logic [15:0] b_rdata;
  logic [2:0]  b_page_q;
  logic [18:0] b_sram_addr;
  wire  [15:0] b_dq;
`ifdef SRAM_BRIDGE_BYTE_EN_EN
  logic [1:0]  b_be = 2'b11;
  logic [1:0]  b_be_n;
`endif

  sram_bridge #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .SRAM_ADDR_W (19),
    .WAIT_STATES (0)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_valid),
    .req_ready  (b_ready),
    .req_we     (b_we),
    .req_addr   (b_addr),
    .req_wdata  (b_wdata),
    .rsp_valid  (b_rsp_valid),
    .rsp_rdata  (b_rdata),
    .page_we    (1'b0),
    .page_wdata (3'h0),
    .page_q     (b_page_q),
    .sram_addr  (b_sram_addr),
`ifdef SRAM_BRIDGE_BYTE_EN_EN
    .req_be     (b_be),
    .sram_be_n  (b_be_n),
`endif
    .sram_dq    (b_dq),
    .sram_ce_n  (b_ce_n),
    .sram_oe_n  (b_oe_n),
    .sram_we_n  (b_we_n)
  );

  assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? (b_sram_addr[15:0] ^ 16'hA5A5) : 16'hzzzz;

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, req_ready, rsp_valid} !== 5'b11110)
      $display("FAIL reset_ctrl: got %b want 11110", {sram_ce_n, sram_oe_n, sram_we_n, req_ready, rsp_valid});
    else n_pass++;
    n_total++;
    if ({rsp_rdata, page_q, sram_addr, dut.dq_oe} !== 39'h0)
      $display("FAIL reset_regs: rdata %h page %h addr %h oe %b want 0", rsp_rdata, page_q, sram_addr, dut.dq_oe);
    else n_pass++;
    rst = 1'b1;
    // Abandon a write while it sits in ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0300; req_wdata = 16'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (rsp_valid !== 1'b0) $display("FAIL reset_mid_rsp: rsp_valid %b want 0", rsp_valid);
      else n_pass++;
    end
    rst = 1'b1;
    n_total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, dut.dq_oe, req_ready} !== 5'b11101)
      $display("FAIL reset_mid_ctrl: ce/oe/we/dq_oe/ready %b want 11101",
               {sram_ce_n, sram_oe_n, sram_we_n, dut.dq_oe, req_ready});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_late_rsp: rsp_valid %b want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_write();
    int   n0, we_low;
    logic drive_ok;
    exp_t e;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'hBEEF;
    @(negedge clk);
    n0 = cyc; req_valid = 1'b0;
    sb.push_back('{1'b0, 16'h0000, n0 + WS + 2});
    we_low = 0; drive_ok = 1'b1;
    for (int d = 0; d < 5; d++) begin
      if (!sram_we_n) we_low++;
      if (dut.dq_oe !== (d <= WS + 1)) drive_ok = 1'b0;
      if (dut.dq_oe && (sram_dq !== 16'hBEEF)) drive_ok = 1'b0;
      if (rsp_valid) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL wr_rsp: unexpected rsp_valid at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if (cyc !== e.due) $display("FAIL wr_rsp_time: got cycle %0d want %0d", cyc, e.due);
          else n_pass++;
        end
      end
      if (d == 3) begin
        n_total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, req_ready} !== 4'b1110)
          $display("FAIL wr_done: ce/oe/we/ready %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, req_ready});
        else n_pass++;
      end
      if (d == 4) begin
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL wr_ready_back: got %b want 1", req_ready);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_total++;
    if (we_low !== 2) $display("FAIL wr_we_low: got %0d cycles want 2", we_low);
    else n_pass++;
    n_total++;
    if (drive_ok !== 1'b1) $display("FAIL wr_dq_drive: got %b want 1", drive_ok);
    else n_pass++;
    n_total++;
    if (sb.size() != 0) $display("FAIL wr_sb_empty: got %0d left want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_read();
    int   n0, oe_low;
    logic driven;
    exp_t e;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    @(negedge clk);
    n0 = cyc; req_valid = 1'b0;
    sb.push_back('{1'b1, 16'hBEEF, n0 + WS + 2});
    oe_low = 0; driven = 1'b0;
    for (int d = 0; d < 5; d++) begin
      if (!sram_oe_n) oe_low++;
      if (dut.dq_oe !== 1'b0) driven = 1'b1;
      if (rsp_valid) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL rd_rsp: unexpected rsp_valid at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if ((cyc !== e.due) || (rsp_rdata !== e.data))
            $display("FAIL rd_rsp: got cycle %0d data %h want cycle %0d data %h", cyc, rsp_rdata, e.due, e.data);
          else n_pass++;
        end
      end
      @(negedge clk);
    end
    n_total++;
    if (oe_low !== 3) $display("FAIL rd_oe_low: got %0d cycles want 3", oe_low);
    else n_pass++;
    n_total++;
    if (driven !== 1'b0) $display("FAIL rd_dq_driven: got %b want 0", driven);
    else n_pass++;
    n_total++;
    if ((rsp_rdata !== 16'hBEEF) || (sb.size() != 0))
      $display("FAIL rd_hold: rdata %h left %0d want BEEF 0", rsp_rdata, sb.size());
    else n_pass++;
  endtask

  task automatic test_page();
    exp_t e;
    page_we = 1'b1; page_wdata = 3'h5;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234;
    sb.push_back('{1'b1, 16'hFFFF, cyc + 1 + WS + 2});
    @(negedge clk);
    page_we = 1'b0; req_valid = 1'b0;
    n_total++;
    if ((sram_addr !== 19'h01234) || (page_q !== 3'h5))
      $display("FAIL page_same_edge: addr %h page %h want 01234 5", sram_addr, page_q);
    else n_pass++;
    page_we = 1'b1; page_wdata = 3'h3;
    @(negedge clk);
    page_we = 1'b0;
    n_total++;
    if ((sram_addr !== 19'h01234) || (page_q !== 3'h3))
      $display("FAIL page_mid_txn: addr %h page %h want 01234 3", sram_addr, page_q);
    else n_pass++;
    page_we = 1'b1; page_wdata = 3'h5;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      page_we = 1'b0;
      if (rsp_valid) begin
        n_total++;
        e = sb.pop_front();
        if ((cyc !== e.due) || (rsp_rdata !== e.data))
          $display("FAIL page_rsp: got cycle %0d data %h want cycle %0d data %h", cyc, rsp_rdata, e.due, e.data);
        else n_pass++;
      end
    end
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_total++;
    if (sram_addr !== 19'h51234) $display("FAIL page_next_req: addr %h want 51234", sram_addr);
    else n_pass++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int          accepted, rsp_cnt, last_acc;
    logic        clash, wd_ok;
    logic [15:0] wd_inflight;
    exp_t        e;
    accepted = 0; rsp_cnt = 0; last_acc = -1; clash = 1'b0; wd_ok = 1'b1; wd_inflight = '0;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 16'h0100; b_wdata = 16'h1111;
    for (int budget = 0; budget < 40 && (accepted < 4 || rsp_cnt < 4); budget++) begin
      if (dut0.dq_oe && !b_oe_n) clash = 1'b1;
      if (!b_we_n && (b_dq !== wd_inflight)) wd_ok = 1'b0;
      if (b_rsp_valid) begin
        rsp_cnt++;
        n_total++;
        if (sb.size() == 0) $display("FAIL b2b_rsp: unexpected rsp_valid at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if ((cyc !== e.due) || (e.is_read && (b_rdata !== e.data)))
            $display("FAIL b2b_rsp: got cycle %0d data %h want cycle %0d data %h", cyc, b_rdata, e.due, e.data);
          else n_pass++;
        end
      end
      if (b_valid && b_ready) begin
        if (last_acc >= 0) begin
          n_total++;
          if (cyc + 1 - last_acc !== 4) $display("FAIL b2b_spacing: got %0d edges want 4", cyc + 1 - last_acc);
          else n_pass++;
        end
        last_acc = cyc + 1;
        sb.push_back('{!b_we, b_addr ^ 16'hA5A5, cyc + 3});
        if (b_we) wd_inflight = b_wdata;
        accepted++;
      end
      @(negedge clk);
      if (accepted >= 4) b_valid = 1'b0;
      else begin
        b_we    = (accepted % 2 == 0);
        b_addr  = 16'h0100 + 16'(accepted);
        b_wdata = 16'h1111 * 16'(accepted + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (b_rsp_valid) rsp_cnt++;
      @(negedge clk);
    end
    n_total++;
    if ((accepted !== 4) || (rsp_cnt !== 4))
      $display("FAIL b2b_count: accepted %0d rsp %0d want 4 4", accepted, rsp_cnt);
    else n_pass++;
    n_total++;
    if ((clash !== 1'b0) || (wd_ok !== 1'b1))
      $display("FAIL b2b_bus: clash %b wdata_ok %b want 0 1", clash, wd_ok);
    else n_pass++;
  endtask

`ifdef SRAM_BRIDGE_BYTE_EN_EN
  task automatic test_byte_en();
    logic be_ok;
    exp_t e;
    be_ok = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'hAA55; req_be = 2'b01;
    @(negedge clk);
    req_valid = 1'b0; req_be = 2'b11;
    for (int d = 0; d < 5; d++) begin
      if ((d <= WS + 1) && (sram_be_n !== 2'b10)) be_ok = 1'b0;
      if ((d > WS + 1) && (sram_be_n !== 2'b11)) be_ok = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (be_ok !== 1'b1) $display("FAIL be_write_lanes: got %b want 1", be_ok);
    else n_pass++;
    req_valid = 1'b1; req_we = 1'b0;
    sb.push_back('{1'b1, 16'hFF55, cyc + 1 + WS + 2});
    @(negedge clk);
    req_valid = 1'b0;
    n_total++;
    if (sram_be_n !== 2'b00) $display("FAIL be_read_lanes: got %b want 00", sram_be_n);
    else n_pass++;
    for (int d = 1; d < 5; d++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n_total++;
        e = sb.pop_front();
        if ((cyc !== e.due) || (rsp_rdata !== e.data))
          $display("FAIL be_readback: got cycle %0d data %h want cycle %0d data %h", cyc, rsp_rdata, e.due, e.data);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_page();
    test_back_to_back();
`ifdef SRAM_BRIDGE_BYTE_EN_EN
    test_byte_en();
`endif
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_final: %0d responses never seen", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Parametrised external asynchronous-SRAM interface between the core's control FSM and the board SRAM.
- Replaces direct SRAM wiring and the hardwired zero upper address bits at core top level.
- Adds a valid/ready request handshake, a response strobe, programmable wait states, controlled chip-enable/output-enable/write-enable strobes, safe tristate turnaround, and a software-writable page register supplying the upper SRAM address bits.

Parameters:
- DATA_W, 16, data bus width in bits; multiple of 8.
- ADDR_W, 16, core-side word address width.
- SRAM_ADDR_W, 19, SRAM address width; must be greater than ADDR_W. Derived PAGE_W = SRAM_ADDR_W - ADDR_W.
- WAIT_STATES, 1, extra ACCESS cycles beyond the first; 0 to 15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept; equals (state == IDLE).
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse for reads and writes.
- rsp_rdata  out  DATA_W  read data; holds until the next read completes.
- page_we  in  1  page register load strobe.
- page_wdata  in  PAGE_W  new page value.
- page_q  out  PAGE_W  current page register value.
- sram_addr  out  SRAM_ADDR_W  {latched page, latched addr}.
- sram_dq  inout  DATA_W  SRAM data bus.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (rst low at a clock edge):
  - State goes to IDLE; ce_n, oe_n and we_n go to 1.
  - sram_dq is released (Z).
  - rsp_valid = 0, rsp_rdata = 0, page_q = 0, sram_addr = 0.
  - Any in-flight transaction is abandoned with no rsp_valid.
- Handshake:
  - Transfer occurs at an edge where req_valid & req_ready are both high.
  - addr, we, wdata and page_q are latched at that edge.
  - req_valid while busy is ignored and not queued.
- State sequence: IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_STATES+1 cycles, counter) -> DONE (1 cycle) -> IDLE.
- Signals per state:
  - SETUP: ce_n = 0. Read: oe_n = 0. Write: we_n = 1 and dq driven with latched data.
  - ACCESS: ce_n = 0. Read: oe_n = 0. Write: we_n = 0 and dq driven.
  - Read capture: on the final ACCESS edge, sram_dq is captured into rsp_rdata.
  - DONE: all strobes = 1, dq = Z (turnaround), rsp_valid = 1 for that cycle only.
- Latency and throughput:
  - For a request accepted at edge N, rsp_valid is high between edges N+WAIT_STATES+2 and N+WAIT_STATES+3.
  - Earliest next accept is edge N+WAIT_STATES+4.
- Bus ownership: sram_dq is driven only in SETUP/ACCESS of a write. It is never driven during a read, in IDLE, or in DONE.
- sram_addr is stable from SETUP through DONE and holds its last value in IDLE.
- Page register:
  - page_we loads page_wdata at any edge.
  - If page_we coincides with an accept, the accepted request uses the old page; the new page applies to later requests.
  - A page change mid-transaction does not alter sram_addr.
- Wait counter width is clog2(WAIT_STATES+1), minimum 1. With WAIT_STATES = 0, ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: SRAM_BRIDGE_BYTE_EN_EN.
- When defined:
  - Adds input req_be[DATA_W/8] and output sram_be_n[DATA_W/8].
  - req_be is latched at accept.
  - In SETUP/ACCESS, sram_be_n = ~be_latched for writes and all-zero for reads.
  - In IDLE/DONE/reset, sram_be_n = all ones.
  - Read data is returned full-width regardless of req_be.
- When undefined: those ports do not exist and every write is full-word.

Decomposition:
- Package sram_bridge_pkg holds:
  - state encoding constants: IDLE, SETUP, ACCESS, DONE;
  - STROBE_ON = 0 and STROBE_OFF = 1;
  - the clog2 helper function.
- One natural sub-module: sram_wait_cnt, a loadable down-counter with a terminal-count output. It is loaded with WAIT_STATES on entry to ACCESS.

Test Plan:
- Reset with rst low for 2 cycles mid-write (in ACCESS) -> next cycle ce_n/we_n/oe_n = 1, dq = Z, no rsp_valid, req_ready = 1.
- WAIT_STATES=1: write addr 16'h0010, data 16'hBEEF at edge N -> we_n low for 2 cycles, dq = BEEF only in SETUP/ACCESS, rsp_valid at N+3, req_ready back after N+4.
- Read back 16'h0010 with the SRAM model -> oe_n low for 3 cycles, dq never driven by the DUT, rsp_rdata = 16'hBEEF with rsp_valid after edge N+3.
- page_we with 3'h5 on the same edge as accepting addr 16'h1234 -> sram_addr = 19'h01234; the next request to 16'h1234 gives sram_addr = 19'h51234.
- Back-to-back req_valid held high for 4 requests with WAIT_STATES=0 -> accepts every 4 edges, exactly 4 rsp_valid pulses, no bus contention.
- With SRAM_BRIDGE_BYTE_EN_EN: write 16'hAA55 with req_be = 2'b01 over 16'hFFFF -> sram_be_n = 2'b10 during write, and readback = 16'hFF55.
